// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the junction phase sequencer and its environment.
// master drives detector calls and the flash request; slave is the sequencer.
interface traffic_phase_sequencer_if #(
  parameter int NUM_PHASES = 6
);
  localparam int IW = $clog2(NUM_PHASES);

  logic [NUM_PHASES-1:0] req;
  logic                  flash_en;
  logic [NUM_PHASES-1:0] green;
  logic [NUM_PHASES-1:0] yellow;
  logic                  flash_out;
  logic [IW-1:0]         phase_idx;
  logic                  phase_start;

  modport master (
    output req, flash_en,
    input  green, yellow, flash_out, phase_idx, phase_start
  );

  modport slave (
    input  req, flash_en,
    output green, yellow, flash_out, phase_idx, phase_start
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Demand-actuated N-phase sequencer: INIT -> GREEN -> YELLOW -> ALL_RED per
// phase, skipping uncalled phases, extending green on live detector presence,
// with a flashing mode entered only from an all-red state. All outputs are
// registered; the output registers are loaded from the next-state values so
// the lamps change on the same edge as the state.
module traffic_phase_sequencer #(
  parameter int NUM_PHASES = 6,
  parameter int TW         = 8,
  parameter int INIT_T     = 3,
  parameter int GMIN       = 4,
  parameter int GMAX       = 20,
  parameter int YEL_T      = 3,
  parameter int RED_T      = 2,
  parameter int FLASH_T    = 8,
  parameter int RECALL     = 0
) (
  input  logic clk,
  input  logic rst,
  traffic_phase_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_PHASES);

  typedef enum logic [2:0] {
    S_INIT,
    S_GREEN,
    S_YELLOW,
    S_ALL_RED,
    S_FLASH
  } state_t;

  state_t                state_reg, state_next;
  logic [TW-1:0]         e_reg, e_next;
  logic [NUM_PHASES-1:0] cl_reg, cl_next;
  logic [IW-1:0]         phase_idx_reg, phase_next;
  logic [NUM_PHASES-1:0] green_reg, green_next;
  logic [NUM_PHASES-1:0] yellow_reg, yellow_next;
  logic                  flash_out_reg, flash_out_next;
  logic                  phase_start_reg;
  // Set when ALL_RED was entered from FLASH: that clearance must end in GREEN.
  logic                  from_flash_reg, from_flash_next;
  logic                  entering;
  logic                  green_entry;
  logic                  flash_toggle;

  logic [NUM_PHASES-1:0] req;
  logic                  flash_en;

  assign req      = bus.req;
  assign flash_en = bus.flash_en;

  assign bus.green       = green_reg;
  assign bus.yellow      = yellow_reg;
  assign bus.flash_out   = flash_out_reg;
  assign bus.phase_idx   = phase_idx_reg;
  assign bus.phase_start = phase_start_reg;

  // First latched call after the current phase, wrapping round and visiting
  // the current phase last; falls back to the recall phase when nothing waits.
  function automatic logic [IW-1:0] pick_next(input logic [NUM_PHASES-1:0] calls,
                                              input logic [IW-1:0] cur);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = IW'(RECALL);
    found = 1'b0;
    for (int k = 1; k <= NUM_PHASES; k++) begin
      idx = int'(cur) + k;
      if (idx >= NUM_PHASES) begin
        idx = idx - NUM_PHASES;
      end
      if (!found && calls[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Next-state decision plus the counters, flags and phase pointer that follow it.
  always_comb begin
    state_next      = state_reg;
    flash_toggle    = 1'b0;
    entering        = 1'b0;
    green_entry     = 1'b0;
    phase_next      = phase_idx_reg;
    e_next          = e_reg + TW'(1);
    flash_out_next  = 1'b0;
    from_flash_next = from_flash_reg;

    case (state_reg)
      S_INIT: begin
        if (e_reg == TW'(INIT_T - 1)) begin
          state_next = flash_en ? S_FLASH : S_GREEN;
        end
      end
      S_GREEN: begin
        // Extension looks at live presence only; a flash request cuts green short.
        if (flash_en || (e_reg == TW'(GMAX - 1)) ||
            ((e_reg >= TW'(GMIN - 1)) && !req[phase_idx_reg])) begin
          state_next = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (e_reg == TW'(YEL_T - 1)) begin
          state_next = S_ALL_RED;
        end
      end
      S_ALL_RED: begin
        if (e_reg == TW'(RED_T - 1)) begin
          state_next = (flash_en && !from_flash_reg) ? S_FLASH : S_GREEN;
        end
      end
      S_FLASH: begin
        if (!flash_en) begin
          state_next = S_ALL_RED;
        end else if (e_reg == TW'(FLASH_T - 1)) begin
          flash_toggle = 1'b1;
        end
      end
      default: begin
        state_next = S_INIT;
      end
    endcase

    entering    = (state_next != state_reg);
    green_entry = entering && (state_next == S_GREEN);

    if (green_entry) begin
      phase_next = pick_next(cl_reg, phase_idx_reg);
    end

    if (entering || flash_toggle) begin
      e_next = '0;
    end

    if (state_next == S_FLASH) begin
      if (entering) begin
        flash_out_next = 1'b1;
      end else if (flash_toggle) begin
        flash_out_next = ~flash_out_reg;
      end else begin
        flash_out_next = flash_out_reg;
      end
    end

    if ((state_reg == S_FLASH) && (state_next == S_ALL_RED)) begin
      from_flash_next = 1'b1;
    end else if (green_entry) begin
      from_flash_next = 1'b0;
    end
  end

  // Per-phase call latch and one-hot lamp vectors; a new call on the entry
  // edge of the served phase wins over the clear so it is served again later.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PHASES; gi++) begin : g_phase
      assign cl_next[gi] = req[gi] |
                           (cl_reg[gi] & ~(green_entry && (phase_next == IW'(gi))));
      assign green_next[gi]  = (state_next == S_GREEN)  && (phase_next == IW'(gi));
      assign yellow_next[gi] = (state_next == S_YELLOW) && (phase_next == IW'(gi));
    end
  endgenerate

  // State, elapsed counter, call latch and phase pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_INIT;
      e_reg          <= '0;
      cl_reg         <= '0;
      phase_idx_reg  <= IW'(NUM_PHASES - 1);
      from_flash_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      e_reg          <= e_next;
      cl_reg         <= cl_next;
      phase_idx_reg  <= phase_next;
      from_flash_reg <= from_flash_next;
    end
  end

  // Registered lamp drives and the first-green pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      green_reg       <= '0;
      yellow_reg      <= '0;
      flash_out_reg   <= 1'b0;
      phase_start_reg <= 1'b0;
    end else begin
      green_reg       <= green_next;
      yellow_reg      <= yellow_next;
      flash_out_reg   <= flash_out_next;
      phase_start_reg <= green_entry;
    end
  end
endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer (4 phases, short timings).
// The output bundle {green, yellow, flash_out, phase_start, phase_idx} is
// treated as a sequence of constant runs. Stimulus pushes the expected runs
// (value and length in clocks); the monitor closes a run whenever the bundle
// changes, pops the next expectation and compares.
// Sample n is the falling edge at time 10*n; inputs set right after sample n
// are seen by the rising edge that ends the cycle shown in sample n.
module tb_traffic_phase_sequencer;
  localparam int NP      = 4;
  localparam int INIT_T  = 3;
  localparam int GMIN    = 4;
  localparam int GMAX    = 8;
  localparam int YEL_T   = 2;
  localparam int RED_T   = 2;
  localparam int FLASH_T = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_on = 1'b0;

  traffic_phase_sequencer_if #(.NUM_PHASES(NP)) bus ();

  traffic_phase_sequencer #(
    .NUM_PHASES(NP), .TW(8), .INIT_T(INIT_T), .GMIN(GMIN), .GMAX(GMAX),
    .YEL_T(YEL_T), .RED_T(RED_T), .FLASH_T(FLASH_T), .RECALL(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] val;
    int          len;
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   now    = 0;
  int   seg_no = 0;

  task automatic expect_seg(input logic [3:0] g, input logic [3:0] y, input logic f,
                            input logic ps, input logic [1:0] idx, input int len);
    seg_t s;
    s.val = {g, y, f, ps, idx};
    s.len = len;
    exp_q.push_back(s);
  endtask

  // One green: a single phase_start cycle, then the rest of the green.
  task automatic expect_green(input int ph, input int len);
    logic [3:0] g;
    g = 4'b0001 << ph;
    expect_seg(g, 4'b0000, 1'b0, 1'b1, 2'(ph), 1);
    expect_seg(g, 4'b0000, 1'b0, 1'b0, 2'(ph), len - 1);
  endtask

  // Full service of a phase: green, yellow, all-red clearance.
  task automatic expect_cycle(input int ph, input int glen);
    logic [3:0] y;
    y = 4'b0001 << ph;
    expect_green(ph, glen);
    expect_seg(4'b0000, y, 1'b0, 1'b0, 2'(ph), YEL_T);
    expect_seg(4'b0000, 4'b0000, 1'b0, 1'b0, 2'(ph), RED_T);
  endtask

  task automatic goto(input int n);
    while (now < n) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic close_seg(input logic [11:0] val, input int len);
    seg_t e;
    seg_no++;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL seg%0d unexpected: got g=%b y=%b f=%b ps=%b idx=%0d len=%0d",
               seg_no, val[11:8], val[7:4], val[3], val[2], val[1:0], len);
    end else begin
      e = exp_q.pop_front();
      if ((val !== e.val) || (len != e.len)) begin
        errors++;
        $display("FAIL seg%0d got g=%b y=%b f=%b ps=%b idx=%0d len=%0d, required g=%b y=%b f=%b ps=%b idx=%0d len=%0d",
                 seg_no, val[11:8], val[7:4], val[3], val[2], val[1:0], len,
                 e.val[11:8], e.val[7:4], e.val[3], e.val[2], e.val[1:0], e.len);
      end else begin
        $display("seg%0d ok g=%b y=%b f=%b ps=%b idx=%0d len=%0d",
                 seg_no, val[11:8], val[7:4], val[3], val[2], val[1:0], len);
      end
    end
  endtask

  // Monitor: run-length encodes the output bundle and checks each finished run.
  initial begin
    logic [11:0] cur;
    logic [11:0] run_val;
    int          run_len;
    bit          active;
    active  = 1'b0;
    run_len = 0;
    run_val = '0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cur = {bus.green, bus.yellow, bus.flash_out, bus.phase_start, bus.phase_idx};
        if (!active) begin
          run_val = cur;
          run_len = 1;
          active  = 1'b1;
        end else if (cur === run_val) begin
          run_len++;
        end else begin
          close_seg(run_val, run_len);
          run_val = cur;
          run_len = 1;
        end
      end
    end
  end

  // Stimulus with hand-derived expected runs.
  initial begin
    bus.req      = '0;
    bus.flash_en = 1'b0;
    mon_on       = 1'b1;
    #1 rst = 1'b0;

    // 1: no calls. Reset samples 1..3 plus INIT e=1,2 -> 5 all-red samples
    // (idx 3), then recall phase 0 at GMIN, yellow, clearance.
    expect_seg(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 3 + INIT_T - 1);
    expect_cycle(0, GMIN);
    goto(3);
    #2 rst = 1'b1;

    // 2: calls on 1 and 3 during phase 0 green (sample 14): order 0,1,3,
    // phase 2 skipped, then back to recall since both latches cleared.
    expect_cycle(0, GMIN);
    expect_cycle(1, GMIN);
    expect_cycle(3, GMIN);
    goto(14);
    bus.req = 4'b1010;
    goto(15);
    bus.req = 4'b0000;

    // 3: req[1] held from sample 38: phase 1 maxes out at GMAX. It is called
    // again while held, so it returns; req[1] drops for its 5th green cycle
    // (sample 62), giving 5 green cycles. The presence during that green
    // re-latches the call, so phase 1 is served once more at GMIN.
    expect_cycle(0, GMIN);
    expect_cycle(1, GMAX);
    expect_cycle(1, 5);
    expect_cycle(1, GMIN);
    goto(38);
    bus.req = 4'b0010;
    goto(62);
    bus.req = 4'b0000;

    // 4: flash_en from green cycle 2 (sample 76): yellow next, full yellow
    // and clearance, then flash 1,1,1,0,0,0,1,1,1. flash_en low in sample 89
    // -> clearance, then green even though flash_en is raised in its last cycle.
    expect_green(0, 2);
    expect_seg(4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, YEL_T);
    expect_seg(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, RED_T);
    expect_seg(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, FLASH_T);
    expect_seg(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, FLASH_T);
    expect_seg(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, FLASH_T);
    expect_seg(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, RED_T);
    expect_cycle(0, GMIN);
    goto(76);
    bus.flash_en = 1'b1;
    goto(89);
    bus.flash_en = 1'b0;
    goto(91);
    bus.flash_en = 1'b1;
    goto(92);
    bus.flash_en = 1'b0;

    // 5: reset asserted mid-yellow (after sample 104): outputs clear at once,
    // idx returns to 3; three reset samples plus INIT e=1,2, then phase 0.
    expect_green(0, GMIN);
    expect_seg(4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0, 1);
    expect_seg(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 3 + INIT_T - 1);
    goto(104);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ((bus.green !== 4'b0000) || (bus.yellow !== 4'b0000) ||
        (bus.flash_out !== 1'b0) || (bus.phase_start !== 1'b0)) begin
      errors++;
      $display("FAIL async_reset_lamps got g=%b y=%b f=%b ps=%b, required all 0",
               bus.green, bus.yellow, bus.flash_out, bus.phase_start);
    end
    checks++;
    if (bus.phase_idx !== 2'd3) begin
      errors++;
      $display("FAIL async_reset_idx got %0d, required 3", bus.phase_idx);
    end
    goto(107);
    #2 rst = 1'b1;

    // 6: call on 2 during phase 0 green (sample 110) -> phase 2 at sample 118.
    // req[2] again in sample 117, the cycle whose closing edge enters that
    // green: the set beats the clear, so phase 2 is served a second time.
    expect_cycle(0, GMIN);
    expect_cycle(2, GMIN);
    expect_cycle(2, GMIN);
    expect_seg(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1);
    goto(110);
    bus.req = 4'b0100;
    goto(111);
    bus.req = 4'b0000;
    goto(117);
    bus.req = 4'b0100;
    goto(118);
    bus.req = 4'b0000;

    goto(136);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d runs outstanding, required 0", exp_q.size());
    end
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog got no finish by 20000, required finish");
    $fatal(1, "watchdog expired");
  end
endmodule
